// File: rtl/iobus_arbiter.sv
// iobus_arbiter: round-robin two-master arbiter serialising transactions onto the single iobus port
//   clk, reset                     clock, async active-high reset
//   mN_req/memwrite/addr/wd        master N request and attributes (held until mN_ack)
//   mN_gnt/ack/rdata               ownership, one-cycle completion pulse, read data during ack
//   bus_memwrite/addr/wd, bus_rd   iobus side
module iobus_arbiter #(
  parameter int RD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic [1:0]  m0_memwrite,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wd,
  output logic        m0_gnt,
  output logic        m0_ack,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic [1:0]  m1_memwrite,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wd,
  output logic        m1_gnt,
  output logic        m1_ack,
  output logic [31:0] m1_rdata,
  output logic [1:0]  bus_memwrite,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wd,
  input  logic [31:0] bus_rd
);
  localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3;
  logic [1:0]  state;
  logic        last_gnt;
  logic        owner;
  logic [2:0]  cnt;
  logic [1:0]  cap_mw;
  logic [31:0] cap_addr;
  logic [31:0] cap_wd;
  logic [31:0] cap_rd;
  logic        pick;
  logic        held;
  logic        resp_rd;
  // on contention the master that did not win last time goes next
  assign pick = (m0_req && m1_req) ? ~last_gnt : m1_req;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      last_gnt <= 1'b1;
      owner    <= 1'b0;
      cnt      <= 3'd0;
      cap_mw   <= 2'd0;
      cap_addr <= 32'd0;
      cap_wd   <= 32'd0;
      cap_rd   <= 32'd0;
    end else begin
      case (state)
        IDLE: if (m0_req || m1_req) begin
          owner    <= pick;
          last_gnt <= pick;
          cap_mw   <= pick ? m1_memwrite : m0_memwrite;
          cap_addr <= pick ? m1_addr : m0_addr;
          cap_wd   <= pick ? m1_wd : m0_wd;
          state    <= ISSUE;
        end
        ISSUE: if (cap_mw != 2'd0) begin
          state <= RESP;
        end else if (RD_LATENCY == 1) begin
          cap_rd <= bus_rd;
          state  <= RESP;
        end else begin
          cnt   <= 3'(RD_LATENCY - 1);
          state <= WAIT;
        end
        WAIT: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) begin
            cap_rd <= bus_rd;
            state  <= RESP;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign held         = (state == ISSUE) || (state == WAIT);
  assign resp_rd      = (state == RESP) && (cap_mw == 2'd0);
  assign m0_gnt       = (state != IDLE) && !owner;
  assign m1_gnt       = (state != IDLE) && owner;
  assign m0_ack       = (state == RESP) && !owner;
  assign m1_ack       = (state == RESP) && owner;
  assign m0_rdata     = (resp_rd && !owner) ? cap_rd : 32'd0;
  assign m1_rdata     = (resp_rd && owner) ? cap_rd : 32'd0;
  assign bus_memwrite = (state == ISSUE) ? cap_mw : 2'd0;
  assign bus_addr     = held ? cap_addr : 32'd0;
  assign bus_wd       = held ? cap_wd : 32'd0;
endmodule
